alaghi_nadder_cfg: RTL and testbench
====================================

Name: alaghi_nadder_cfg

Overview:
Configurable N-input stochastic adder built on the counter-based (Alaghi) deterministic scaled-add scheme.
- Each valid cycle it popcounts the enabled input bits into a residue accumulator and emits one output stream bit.
- Adds a runtime channel mask, a scaled/saturating mode, valid qualification and output statistics counters.
- Sits between stochastic number generators and the downstream stream consumer or counter-based converter.

Parameters:
INPUT_STREAMS, 31, number of input bitstreams N (>=2).
SAT_CAP, 7, maximum residue carried in saturating mode (1..2N).
OCNT_WIDTH, 16, width of the output statistics counters.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately.
inpts  input  INPUT_STREAMS  one bit per input stream this cycle.
in_valid  input  1  inpts qualified this cycle.
cfg_load  input  1  load cfg_mask/cfg_mode and clear the accumulator and counters.
cfg_mask  input  INPUT_STREAMS  channel enable mask; bit=0 ignores that stream.
cfg_mode  input  1  0 = scaled add (sum/K); 1 = saturating add.
out  output  1  result stream bit, registered.
out_valid  output  1  out is meaningful this cycle.
out_ones  output  OCNT_WIDTH  count of out=1 bits since last clear.
sample_cnt  output  OCNT_WIDTH  count of out_valid cycles since last clear.

Behaviour:
- Reset (rst=0, async): acc=0, out=0, out_valid=0, out_ones=0, sample_cnt=0, mask=all ones, mode=0, K=INPUT_STREAMS.
- cfg_load=1 at an edge: mask<=cfg_mask, mode<=cfg_mode, K<=popcount(cfg_mask), acc<=0, counters<=0, out_valid<=0.
  - cfg_load has priority; an in_valid sample in the same cycle is dropped.
- Widths: pc = popcount(inpts & mask), CW = clog2(N+1) bits.
  - Accumulator width AW = clog2(max(2N, SAT_CAP+N+1)).
  - No overflow is permitted; sums are computed at AW+1 bits.
- Scaled mode (mode=0), on in_valid=1: s = acc + pc.
  - If K=0: out<=0, acc held.
  - Else if s >= K: out<=1, acc<=s-K.
  - Else: out<=0, acc<=s.
- Saturating mode (mode=1), on in_valid=1: s = acc + pc.
  - If s >= 1: out<=1, acc<=min(s-1, SAT_CAP).
  - Else: out<=0, acc<=0.
- Latency: one cycle. out and out_valid update at the edge sampling in_valid.
  - in_valid=0: out_valid<=0, out<=0, acc held.
- Counters on each out_valid-producing edge: sample_cnt += 1; out_ones += out_next.
  - When sample_cnt equals all ones, both counters freeze until cfg_load or reset; out/out_valid continue.
- Invariants: scaled mode acc < K; saturating mode acc <= SAT_CAP.
- Mask or mode change takes effect only through cfg_load; cfg_* are ignored otherwise.

Test Plan:
- N=31, default config after reset, inpts all ones, in_valid=1 for 9 cycles -> out=1 each cycle from cycle 1; out_ones=9, sample_cnt=9, acc=0.
- N=4, mask 4'b1111, mode 0, inpts=4'b0011 for 8 cycles -> out=0,1,0,1,0,1,0,1; out_ones=4, sample_cnt=8.
- N=4, cfg_load mask 4'b0101 (K=2), mode 0; inpts=4'b0001 for 4 cycles -> out=0,1,0,1. Then inpts=4'b1111 -> out=1 every cycle (masked pc=2).
- N=4, SAT_CAP=3, mode 1; inpts=4'b1111 for 3 cycles, then 4'b0000 for 5 cycles -> out=1,1,1,1,1,1,0,0; out_ones=6, sample_cnt=8.
- cfg_load with mask=0 and mode 0, then 5 valid cycles of all-ones inpts -> out=0 throughout, out_ones=0, sample_cnt=5.
- Boundary cases:
  - cfg_load and in_valid in the same cycle -> out_valid=0 next cycle, counters 0.
  - rst driven low between clock edges mid-stream -> out, out_valid and counters 0 before the next edge.
  - OCNT_WIDTH=4, 20 valid all-ones cycles -> sample_cnt=15, out_ones=15, both frozen.

Source files
------------

// File: rtl/alaghi_nadder_cfg.sv
// alaghi_nadder_cfg: configurable N-input counter-based stochastic adder with masking, scaled/saturating modes and output statistics
module alaghi_nadder_cfg #(
  parameter int INPUT_STREAMS = 31,
  parameter int SAT_CAP = 7,
  parameter int OCNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INPUT_STREAMS-1:0] inpts,
  input  logic                     in_valid,
  input  logic                     cfg_load,
  input  logic [INPUT_STREAMS-1:0] cfg_mask,
  input  logic                     cfg_mode,
  output logic                     out,
  output logic                     out_valid,
  output logic [OCNT_WIDTH-1:0]    out_ones,
  output logic [OCNT_WIDTH-1:0]    sample_cnt
);
  localparam int N = INPUT_STREAMS;
  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2((2 * N > SAT_CAP + N + 1) ? 2 * N : SAT_CAP + N + 1);
  localparam int SW = AW + 1;
  logic [N-1:0] mask_q;
  logic mode_q, out_q, out_valid_q, out_d;
  logic [CW-1:0] k_q, pc, cfg_pc;
  logic [AW-1:0] acc_q, acc_d, sat;
  logic [SW-1:0] s, s_m1;
  logic [OCNT_WIDTH-1:0] ones_q, cnt_q;
  // popcounts of the live masked inputs and of the mask being loaded
  always_comb begin
    pc = '0;
    cfg_pc = '0;
    for (int i = 0; i < N; i++) begin
      pc = pc + CW'(inpts[i] & mask_q[i]);
      cfg_pc = cfg_pc + CW'(cfg_mask[i]);
    end
  end
  // residue update: scaled mode subtracts K on overflow, saturating mode emits while residue remains
  always_comb begin
    s = SW'(acc_q) + SW'(pc);
    s_m1 = s - SW'(1);
    sat = (s_m1 > SW'(SAT_CAP)) ? AW'(SAT_CAP) : AW'(s_m1);
    out_d = mode_q ? (s != '0) : (k_q != '0 && s >= SW'(k_q));
    acc_d = mode_q ? ((s == '0) ? '0 : sat)
                   : ((k_q == '0) ? acc_q : (out_d ? AW'(s - SW'(k_q)) : AW'(s)));
  end
  // configuration, accumulator, registered output and saturating-freeze statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '1;
      mode_q <= 1'b0;
      k_q <= CW'(N);
      acc_q <= '0;
      out_q <= 1'b0;
      out_valid_q <= 1'b0;
      ones_q <= '0;
      cnt_q <= '0;
    end else if (cfg_load) begin
      mask_q <= cfg_mask;
      mode_q <= cfg_mode;
      k_q <= cfg_pc;
      acc_q <= '0;
      out_q <= 1'b0;
      out_valid_q <= 1'b0;
      ones_q <= '0;
      cnt_q <= '0;
    end else begin
      out_q <= in_valid & out_d;
      out_valid_q <= in_valid;
      if (in_valid) begin
        acc_q <= acc_d;
        if (~&cnt_q) begin
          cnt_q <= cnt_q + 1'b1;
          ones_q <= ones_q + OCNT_WIDTH'(out_d);
        end
      end
    end
  end
  assign out = out_q;
  assign out_valid = out_valid_q;
  assign out_ones = ones_q;
  assign sample_cnt = cnt_q;
endmodule

// File: tb/tb_alaghi_nadder_cfg.sv
// tb_alaghi_nadder_cfg: table-driven, directed and randomized model-checked bench for alaghi_nadder_cfg
module tb_alaghi_nadder_cfg;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic [30:0] in31 = '0, m31 = '0;
  logic v31 = 1'b0, ld31 = 1'b0, md31 = 1'b0, o31, ov31;
  logic [15:0] ones31, sc31;
  logic [3:0] in4 = '0, m4 = '0, ones4, sc4;
  logic v4 = 1'b0, ld4 = 1'b0, md4 = 1'b0, o4, ov4;
  alaghi_nadder_cfg u31 (.clk(clk), .rst(rst), .inpts(in31), .in_valid(v31), .cfg_load(ld31),
    .cfg_mask(m31), .cfg_mode(md31), .out(o31), .out_valid(ov31), .out_ones(ones31), .sample_cnt(sc31));
  alaghi_nadder_cfg #(.INPUT_STREAMS(4), .SAT_CAP(3), .OCNT_WIDTH(4)) u4 (.clk(clk), .rst(rst),
    .inpts(in4), .in_valid(v4), .cfg_load(ld4), .cfg_mask(m4), .cfg_mode(md4), .out(o4),
    .out_valid(ov4), .out_ones(ones4), .sample_cnt(sc4));
  typedef struct {
    logic [3:0] inp;
    logic v, ld;
    logic [3:0] m;
    logic md, eo, eov;
    int eones, esc;
  } vec_t;
  vec_t tbl[$];
  int nvec = 0, nerr = 0;
  int macc, mk, mones, msc, ms, mo, mov, mmode;
  logic [3:0] mmask;
  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic [3:0] inp, input logic v, input logic ld, input logic [3:0] m,
                     input logic md, input logic eo, input logic eov, input int eones, input int esc);
    vec_t r;
    r.inp = inp; r.v = v; r.ld = ld; r.m = m; r.md = md;
    r.eo = eo; r.eov = eov; r.eones = eones; r.esc = esc;
    tbl.push_back(r);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk4(input string name, input int eo, input int eov, input int eones, input int esc);
    chk({name, ".out"}, int'(o4), eo);
    chk({name, ".out_valid"}, int'(ov4), eov);
    chk({name, ".out_ones"}, int'(ones4), eones);
    chk({name, ".sample_cnt"}, int'(sc4), esc);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    add(4'h0, 0, 1, 4'hf, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(4'b0011, 1, 0, 4'hf, 0, i % 2 == 0, 1, i / 2, i);
    add(4'h0, 0, 1, 4'b0101, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(4'b0001, 1, 0, 4'b0101, 0, i % 2 == 0, 1, i / 2, i);
    for (int i = 1; i <= 3; i++) add(4'b1111, 1, 0, 4'b0101, 0, 1, 1, 2 + i, 4 + i);
    add(4'h0, 0, 1, 4'hf, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(i <= 3 ? 4'hf : 4'h0, 1, 0, 4'hf, 1, i <= 6, 1, i <= 6 ? i : 6, i);
    add(4'h0, 0, 1, 4'h0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) add(4'hf, 1, 0, 4'h0, 0, 0, 1, 0, i);
    add(4'h0, 0, 1, 4'hf, 0, 0, 0, 0, 0);
    add(4'hf, 1, 0, 4'hf, 0, 1, 1, 1, 1);
    add(4'hf, 1, 1, 4'hf, 0, 0, 0, 0, 0);
    add(4'h0, 0, 0, 4'hf, 0, 0, 0, 0, 0);
    add(4'b0011, 1, 0, 4'hf, 0, 0, 1, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out", int'(o31), 0);
    chk("rst.out_valid", int'(ov31), 0);
    chk("rst.out_ones", int'(ones31), 0);
    chk("rst.sample_cnt", int'(sc31), 0);
    @(negedge clk);
    rst = 1'b1;
    in31 = '1;
    v31 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("n31.out", int'(o31), 1);
      chk("n31.out_valid", int'(ov31), 1);
    end
    chk("n31.out_ones", int'(ones31), 9);
    chk("n31.sample_cnt", int'(sc31), 9);
    in31 = 31'h7fff_fffe;
    step();
    chk("n31.acc_zero", int'(o31), 0);
    in31 = '1;
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    chk("async.out", int'(o31), 0);
    chk("async.out_valid", int'(ov31), 0);
    chk("async.out_ones", int'(ones31), 0);
    chk("async.sample_cnt", int'(sc31), 0);
    v31 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) begin
      in4 = tbl[i].inp;
      v4 = tbl[i].v;
      ld4 = tbl[i].ld;
      m4 = tbl[i].ld ? tbl[i].m : ~tbl[i].m;
      md4 = tbl[i].ld ? tbl[i].md : ~tbl[i].md;
      step();
      chk4($sformatf("tbl[%0d]", i), tbl[i].eo, tbl[i].eov, tbl[i].eones, tbl[i].esc);
    end
    ld4 = 1'b1; m4 = 4'hf; md4 = 1'b0; v4 = 1'b0;
    step();
    ld4 = 1'b0; in4 = 4'hf; v4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("freeze.out", int'(o4), 1);
    end
    chk("freeze.sample_cnt", int'(sc4), 15);
    chk("freeze.out_ones", int'(ones4), 15);
    in4 = 4'h0;
    repeat (2) step();
    chk4("freeze.after", 0, 1, 15, 15);
    ld4 = 1'b1; m4 = 4'hf; md4 = 1'b0; v4 = 1'b0;
    step();
    macc = 0; mmask = 4'hf; mmode = 0; mones = 0; msc = 0;
    for (int i = 0; i < 400; i++) begin
      ld4 = ($urandom_range(0, 15) == 0);
      v4 = ($urandom_range(0, 3) != 0);
      in4 = 4'($urandom);
      m4 = 4'($urandom);
      md4 = 1'($urandom);
      if (ld4) begin
        mmask = m4; mmode = int'(md4); macc = 0; mones = 0; msc = 0; mo = 0; mov = 0;
      end else if (v4) begin
        mk = $countones(mmask);
        ms = macc + $countones(in4 & mmask);
        if (mmode == 0) begin
          mo = (mk != 0 && ms >= mk) ? 1 : 0;
          macc = (mk == 0) ? macc : (mo == 1 ? ms - mk : ms);
        end else begin
          mo = (ms >= 1) ? 1 : 0;
          macc = (ms >= 1) ? ((ms - 1 > 3) ? 3 : ms - 1) : 0;
        end
        mov = 1;
        if (msc != 15) begin
          msc++;
          mones += mo;
        end
      end else begin
        mo = 0; mov = 0;
      end
      step();
      chk4("rand", mo, mov, mones, msc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
